// File: rtl/wmem_ctrl_pkg.sv
// Shared types and constants for the weight-memory controller.
// Optional feature macro used by the top level: WMEM_CTRL_PERF_EN.
package wmem_ctrl_pkg;

    // Controller FSM states; the encoding is visible to anything that imports the package.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // cmd_op encodings.
    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_STREAM = 1'b1;

endpackage

// File: rtl/wmem_ctrl_memory_block.sv
// Simple dual-port weight storage: one write port, one read port with a
// single cycle of read latency. Contents are not initialised and are not
// touched by reset; reset only clears the read data register.
module memory_block #(
    parameter int DATAW = 128,
    parameter int DEPTH = 64,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic             re,
    input  logic [ADDRW-1:0] raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem [DEPTH];

    // Write port: storage survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: data appears one edge after the read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wmem_ctrl.sv
// Weight-memory controller: LOAD writes an AXI-stream burst into the weight
// memory, STREAM reads a burst back out on an AXI-stream master through a
// two-entry output buffer so no beat is lost under any tready pattern.
// Optional build macro WMEM_CTRL_PERF_EN adds the stall_cnt output.
//
// Handshakes: every channel uses valid/ready; a transfer happens on the
// rising edge where both are high; a source holds valid and its payload
// steady until that edge, and a sink may raise or drop ready freely.
module wmem_ctrl
    import wmem_ctrl_pkg::*;
#(
    parameter int DATAW = 128,
    parameter int DEPTH = 64,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [ADDRW-1:0] cmd_base,
    input  logic [ADDRW-1:0] cmd_len,
    input  logic [DATAW-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [DATAW-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             load_err
`ifdef WMEM_CTRL_PERF_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [ADDRW:0] DEPTH_W = (ADDRW + 1)'(DEPTH);

    // Address arithmetic modulo DEPTH (both operands are already < DEPTH).
    function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] a,
                                                  input logic [ADDRW-1:0] b);
        logic [ADDRW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= DEPTH_W) begin
            s = s - DEPTH_W;
        end
        return s[ADDRW-1:0];
    endfunction

    state_t           state;
    logic [ADDRW-1:0] base_q;
    logic [ADDRW-1:0] len_q;
    logic [ADDRW-1:0] wr_idx;
    logic [ADDRW-1:0] rd_idx;
    logic             rd_done;

    // Read pipeline: infl_* tracks the read whose data is on mem_rdata now.
    logic             infl_v;
    logic             infl_last;
    logic [1:0]       buf_cnt;
    logic [DATAW-1:0] buf_data [2];
    logic             buf_last [2];

    logic             cmd_fire;
    logic             s_fire;
    logic             m_fire;
    logic [1:0]       occ_after;
    logic             rd_issue;
    logic             mem_we;
    logic [ADDRW-1:0] mem_waddr;
    logic [ADDRW-1:0] mem_raddr;
    logic [DATAW-1:0] mem_rdata;

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign s_axis_tready = (state == ST_LOAD);
    assign m_axis_tvalid = (buf_cnt != 2'd0);
    assign m_axis_tdata  = buf_data[0];
    assign m_axis_tlast  = buf_last[0];

    assign cmd_fire = cmd_valid && cmd_ready;
    assign s_fire   = s_axis_tvalid && s_axis_tready;
    assign m_fire   = m_axis_tvalid && m_axis_tready;

    // A read may go out only if the entries left after this cycle's pop,
    // plus the read already in flight, leave room for it in the buffer.
    // Counting the pop keeps one beat per cycle when tready stays high.
    assign occ_after = buf_cnt - 2'(m_fire) + 2'(infl_v);
    assign rd_issue  = (state == ST_STREAM) && !rd_done && (occ_after < 2'd2) && !rst;

    assign mem_we    = s_fire && !rst;
    assign mem_waddr = wrap_add(base_q, wr_idx);
    assign mem_raddr = wrap_add(base_q, rd_idx);

    memory_block #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (s_axis_tdata),
        .re    (rd_issue),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Control FSM: command accept, LOAD beat counting / error, STREAM read issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            rd_done  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        base_q  <= cmd_base;
                        len_q   <= cmd_len;
                        wr_idx  <= '0;
                        rd_idx  <= '0;
                        rd_done <= 1'b0;
                        state   <= (cmd_op == OP_STREAM) ? ST_STREAM : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_fire) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == len_q) begin
                            state    <= ST_IDLE;
                            load_err <= !s_axis_tlast;
                        end else if (s_axis_tlast) begin
                            state    <= ST_IDLE;
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (rd_issue) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == len_q) begin
                            rd_done <= 1'b1;
                        end
                    end
                    if (m_fire && m_axis_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // In-flight read tracking: the tag follows the read by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_v    <= 1'b0;
            infl_last <= 1'b0;
        end else begin
            infl_v    <= rd_issue;
            infl_last <= rd_issue && (rd_idx == len_q);
        end
    end

    // Two-entry output buffer; entry 0 drives the master stream.
    always_ff @(posedge clk) begin
        if (rst || (m_fire && m_axis_tlast)) begin
            buf_cnt     <= 2'd0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else begin
            case ({infl_v, m_fire})
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    buf_cnt     <= buf_cnt - 2'd1;
                end
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_data[0] <= mem_rdata;
                        buf_last[0] <= infl_last;
                    end else begin
                        buf_data[1] <= mem_rdata;
                        buf_last[1] <= infl_last;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_data[0] <= mem_rdata;
                        buf_last[0] <= infl_last;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_last[0] <= buf_last[1];
                        buf_data[1] <= mem_rdata;
                        buf_last[1] <= infl_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef WMEM_CTRL_PERF_EN
    // Saturating count of master-stream stall cycles, restarted per STREAM command.
    always_ff @(posedge clk) begin
        if (rst || (cmd_fire && (cmd_op == OP_STREAM))) begin
            stall_cnt <= 16'd0;
        end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wmem_ctrl.sv
// Bench for wmem_ctrl: directed and random LOAD/STREAM traffic checked
// against a plain array model of the weight memory and an expected-beat queue.
module tb_wmem_ctrl;

  localparam int DATAW = 128;
  localparam int DEPTH = 64;
  localparam int ADDRW = 6;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [ADDRW-1:0] cmd_base;
  logic [ADDRW-1:0] cmd_len;
  logic [DATAW-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [DATAW-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             busy;
  logic             load_err;
`ifdef WMEM_CTRL_PERF_EN
  logic [15:0]      stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATAW-1:0] ref_mem [DEPTH];
  logic [DATAW:0]   exp_q [$];

  wmem_ctrl #(.DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_base      (cmd_base),
    .cmd_len       (cmd_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .load_err      (load_err)
`ifdef WMEM_CTRL_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DATAW+1:0] obs, input logic [DATAW+1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // driver: command handshake; returns at 1 time unit after the accept edge
  task automatic send_cmd(input logic op, input int base, input int len);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = ADDRW'(base);
    cmd_len   = ADDRW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy_after_cmd", busy, 1);
    check("cmd_ready_after_cmd", cmd_ready, 0);
  endtask

  // driver: LOAD burst; tlast_at > len means tlast is never driven,
  // rst_at >= 0 pulses reset together with that beat
  task automatic load(input int base, input int len, input int tlast_at,
                      input int rst_at, input bit idx_data);
    int last_beat;
    bit exp_err;
    logic [DATAW-1:0] d;
    last_beat = (tlast_at < len) ? tlast_at : len;
    exp_err   = (tlast_at != len);
    send_cmd(1'b0, base, len);
    for (int b = 0; b <= last_beat; b++) begin
      d = idx_data ? DATAW'(b) : rand_word();
      if ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      check("s_tready_in_load", s_axis_tready, 1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = (b == tlast_at);
      if (b == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("load_rst_cmd_ready", cmd_ready, 1);
        check("load_rst_s_tready", s_axis_tready, 0);
        return;
      end
      @(posedge clk); #1;
      ref_mem[(base + b) % DEPTH] = d;
      if (b != last_beat) check("load_err_mid", load_err, 0);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("load_err_end", load_err, exp_err);
    check("load_idle", cmd_ready, 1);
    check("load_s_tready_off", s_axis_tready, 0);
    @(posedge clk); #1;
    check("load_err_one_cycle", load_err, 0);
  endtask

  // driver + scoreboard: STREAM burst
  task automatic stream(input int base, input int len, input int ready_pct,
                        input int abort_at, input int hold_at, input int hold_n);
    int got = 0;
    int cyc = 0;
    int first = -1;
    int hold_left = 0;
    bit held = 0;
    bit stall = 0;
    bit acc;
    logic [DATAW-1:0] pd;
    logic pl;
    logic [DATAW:0] e;
    exp_q.delete();
    for (int i = 0; i <= len; i++) exp_q.push_back({(i == len), ref_mem[(base + i) % DEPTH]});
    m_axis_tready = 1'b0;
    send_cmd(1'b1, base, len);
`ifdef WMEM_CTRL_PERF_EN
    check("stall_cnt_clear", stall_cnt, 0);
`endif
    while (got <= len && cyc < 1000) begin
      if (got == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_tvalid", m_axis_tvalid, 0);
        check("abort_tlast", m_axis_tlast, 0);
        check("abort_tdata", m_axis_tdata, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        exp_q.delete();
        return;
      end
      if (m_axis_tvalid && first < 0) first = cyc;
      if (stall) begin
        check("stall_tvalid_held", m_axis_tvalid, 1);
        check("stall_payload_held", {m_axis_tlast, m_axis_tdata}, {pl, pd});
      end
      if (got == hold_at && !held) begin
        held = 1;
        hold_left = hold_n;
      end
      if (hold_left > 0) begin
        m_axis_tready = 1'b0;
        hold_left--;
      end else begin
        m_axis_tready = ($urandom_range(0, 99) < ready_pct);
      end
      acc   = m_axis_tvalid && m_axis_tready;
      stall = m_axis_tvalid && !m_axis_tready;
      pd    = m_axis_tdata;
      pl    = m_axis_tlast;
      if (acc) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_axis_tlast, m_axis_tdata}, e);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("beats_received", got, len + 1);
    check("first_tvalid_edge", first, 2);
    if (ready_pct == 100 && hold_n == 0) check("full_rate_cycles", cyc, len + 3);
    check("stream_idle_after_last", cmd_ready, 1);
    check("stream_tvalid_off", m_axis_tvalid, 0);
`ifdef WMEM_CTRL_PERF_EN
    if (hold_n > 0) check("stall_cnt", stall_cnt, 16'(hold_n));
`endif
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_base = '0;
    cmd_len = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_load_err", load_err, 0);

    // s_axis beats while idle are ignored
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand_word();
    @(posedge clk); #1;
    check("idle_s_tready", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;

    // full fill with index data, full-rate readback
    load(0, 63, 63, -1, 1'b1);
    stream(0, 63, 100, -1, -1, 0);
    // back-to-back wrap-around read
    stream(62, 3, 100, -1, -1, 0);

    // random data, 50% ready
    load(10, 15, 15, -1, 1'b0);
    stream(10, 15, 50, -1, -1, 0);

    // early tlast on beat 3 of len 7
    load(40, 7, 3, -1, 1'b0);
    stream(38, 11, 100, -1, -1, 0);

    // missing tlast, wrapping load
    load(60, 5, 99, -1, 1'b0);
    stream(58, 9, 70, -1, -1, 0);

    // reset mid-load keeps earlier beats, drops the rest
    load(20, 6, 6, 3, 1'b0);
    stream(18, 10, 100, -1, -1, 0);

    // single-beat transfer
    stream(5, 0, 100, -1, -1, 0);
    stream(63, 0, 30, -1, -1, 0);

    // reset mid-stream, then re-run
    stream(0, 20, 100, 5, -1, 0);
    stream(0, 20, 100, -1, -1, 0);

    // random traffic
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        int ln;
        ln = $urandom_range(0, 20);
        load($urandom_range(0, DEPTH - 1), ln, ln, -1, 1'b0);
      end else begin
        stream($urandom_range(0, DEPTH - 1), $urandom_range(0, 25),
               $urandom_range(20, 100), -1, -1, 0);
      end
    end

`ifdef WMEM_CTRL_PERF_EN
    // ten stall cycles mid-stream
    stream(0, 30, 100, -1, 8, 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wmem_ctrl.md
WMEM_CTRL -- requirements
Module: wmem_ctrl

Interface
REQ-001 SHALL have parameter DATAW, default 128, meaning word width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning words in the weight memory.
REQ-003 SHALL have parameter ADDRW, default $clog2(DEPTH), meaning address width.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_op  in  1  0 = LOAD, 1 = STREAM.
REQ-008 cmd_base  in  ADDRW  first word address.
REQ-009 cmd_len  in  ADDRW  beat count minus one.
REQ-010 s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATAW/1/1/1  load stream.
REQ-011 m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATAW/1/1/1  weight output stream.
REQ-012 busy  out  1  state is not IDLE.
REQ-013 load_err  out  1  one-cycle pulse on a LOAD length/tlast mismatch.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD and STREAM; cmd_ready = 1 only in IDLE.
REQ-015 On a cmd handshake SHALL latch base and len, and move to LOAD or STREAM per cmd_op at the same edge.
REQ-016 LOAD SHALL hold s_axis_tready = 1; beat i SHALL write mem[(base+i) mod DEPTH] on the same edge as its handshake.
REQ-017 LOAD SHALL return to IDLE after beat len; tlast early (abort there) or missing on beat len SHALL pulse load_err once; written beats stay written.
REQ-018 STREAM SHALL read addresses (base+i) mod DEPTH, i = 0..len, in order; address arithmetic SHALL wrap past DEPTH-1 to 0.
REQ-019 With 1-cycle memory read latency, reads SHALL be issued only when (buffered + in-flight) < 2, via a 2-entry output buffer; zero beats lost or duplicated under any tready pattern.
REQ-020 First m_axis_tvalid SHALL rise 2 edges after the STREAM cmd edge; with tready held at 1, throughput SHALL be 1 beat/cycle.
REQ-021 m_axis_tvalid/tdata/tlast SHALL hold stable while tvalid && !tready.
REQ-022 m_axis_tlast SHALL be 1 only on beat len; STREAM SHALL return to IDLE at the edge that accepts that beat.
REQ-023 A new cmd in the IDLE cycle right after completion SHALL be accepted (no dead cycle beyond cmd_ready).
REQ-024 cmd_len = 0 SHALL transfer exactly one beat, with tlast on it.
REQ-025 s_axis beats outside LOAD SHALL be ignored (tready = 0).

Reset
REQ-026 rst SHALL force IDLE, cmd_ready = 1, busy = 0, s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0 and load_err = 0, and flush the buffer and in-flight read.
REQ-027 rst mid-LOAD or mid-STREAM SHALL abort with no further writes, while memory contents are preserved.

Configuration
REQ-028 With WMEM_CTRL_PERF_EN defined, the block SHALL have output stall_cnt[15:0], which counts cycles with m_axis_tvalid && !m_axis_tready, saturates at 16'hFFFF, and clears on rst and on each STREAM cmd accept.
REQ-029 Without WMEM_CTRL_PERF_EN, stall_cnt and its logic SHALL be absent.

Structure
REQ-030 Package wmem_ctrl_pkg SHALL hold the state enum and the OP_LOAD/OP_STREAM constants.
REQ-031 The block SHALL instantiate one memory_block (DATAW, DEPTH, no init) as its storage sub-module; its rst input SHALL be tied to rst.

Verification
REQ-032 LOAD base=0 len=63 with data = index, then STREAM base=0 len=63 with tready=1 -> 64 beats data 0..63, tlast on beat 63, tvalid first high 2 edges after cmd.
REQ-033 STREAM base=62 len=3 -> data from addresses 62,63,0,1, tlast on the 4th beat.
REQ-034 STREAM len=15 with tready random at 50% -> 16 beats in order, no drops or duplicates, data held stable during stalls.
REQ-035 LOAD len=7 with tlast on beat 3 -> load_err pulses 1 cycle, FSM back to IDLE, addresses base..base+3 written.
REQ-036 rst asserted at beat 5 of STREAM len=20 -> tvalid=0 on the next cycle, cmd_ready=1; a re-run returns the unchanged data.
REQ-037 With WMEM_CTRL_PERF_EN: tready=0 for 10 cycles mid-stream -> stall_cnt = 10.
